// File: rtl/fpu_mul_result_collector.sv
// Capture FIFO for FPU multiplier results with sticky IEEE flags and a
// saturating operation counter.
module fpu_mul_result_collector #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_res,
  input  logic                       in_exception,
  input  logic                       in_overflow,
  input  logic                       in_underflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_res,
  output logic [2:0]                 out_flags,
  output logic [2:0]                 sticky_flags,
  output logic [CNT_W-1:0]           op_count,
  input  logic                       clr,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = 35;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [2:0]    in_flags;
  logic [EW-1:0] head;

  assign in_flags  = {in_exception, in_overflow, in_underflow};
  assign in_ready  = (level != LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry is forced to zero while the FIFO is empty
  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_res   = head[EW-1:3];
  assign out_flags = head[2:0];

  // Storage array; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_res, in_flags};
    end
  end

  // Pointers and occupancy; push+pop in one cycle leaves level unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
    end
  end

  // Sticky flags and saturating counter; a push in the clear cycle survives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
      op_count     <= '0;
    end else if (clr) begin
      sticky_flags <= push ? in_flags : 3'b000;
      op_count     <= push ? CNT_W'(1) : '0;
    end else if (push) begin
      sticky_flags <= sticky_flags | in_flags;
      if (op_count != '1) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fpu_mul_result_collector.sv
// Directed self-checking bench for fpu_mul_result_collector (DEPTH=4, CNT_W=4).
module tb_fpu_mul_result_collector;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_res;
  logic              in_exception;
  logic              in_overflow;
  logic              in_underflow;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_res;
  logic [2:0]        out_flags;
  logic [2:0]        sticky_flags;
  logic [CNT_W-1:0]  op_count;
  logic              clr;
  logic [2:0]        level;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] fw [4];
  logic [31:0] exp_q [$];
  logic [31:0] w;

  fpu_mul_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res),
    .in_exception(in_exception), .in_overflow(in_overflow), .in_underflow(in_underflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags),
    .sticky_flags(sticky_flags), .op_count(op_count), .clr(clr), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [2:0] f);
    {in_exception, in_overflow, in_underflow} = f;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    fw[0] = 32'h42355062;
    fw[1] = 32'h441E5374;
    fw[2] = 32'h49B9E220;
    fw[3] = 32'h310351DD;

    rst = 1'b1; in_valid = 1'b0; in_res = '0; set_flags(3'b000);
    out_ready = 1'b0; clr = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_res", 64'(out_res), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single word, one-cycle latency, then pop
    in_valid = 1'b1; in_res = 32'h453210E9; set_flags(3'b000);
    tick();
    in_valid = 1'b0;
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_res", 64'(out_res), 64'h453210E9);
    chk("single_level", 64'(level), 64'd1);
    chk("single_count", 64'(op_count), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_pop_valid", 64'(out_valid), 64'd0);
    chk("single_pop_res", 64'(out_res), 64'd0);
    chk("single_pop_level", 64'(level), 64'd0);

    // Fill to full with flags 0..3
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_res = fw[i]; set_flags(3'(i));
      tick();
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_level", 64'(level), 64'd4);
    chk("full_count", 64'(op_count), 64'd5);
    chk("full_sticky", 64'(sticky_flags), 64'd3);
    in_res = 32'hDEADBEEF; set_flags(3'b111);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_hold_level", 64'(level), 64'd4);
      chk("full_hold_count", 64'(op_count), 64'd5);
    end
    // Pop while full with in_valid still high: no bypass
    out_ready = 1'b1;
    chk("drain_res0", 64'(out_res), 64'(fw[0]));
    chk("drain_flags0", 64'(out_flags), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("nobypass_level", 64'(level), 64'd3);
    chk("nobypass_count", 64'(op_count), 64'd5);
    for (int i = 1; i < 4; i++) begin
      chk("drain_res", 64'(out_res), 64'(fw[i]));
      chk("drain_flags", 64'(out_flags), 64'(3'(i)));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty_valid", 64'(out_valid), 64'd0);
    chk("drain_empty_level", 64'(level), 64'd0);

    // Sticky flags and clear
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_sticky", 64'(sticky_flags), 64'd0);
    chk("clr_count", 64'(op_count), 64'd0);
    in_valid = 1'b1; in_res = 32'h3F800000; set_flags(3'b010);
    tick();
    chk("sticky_010", 64'(sticky_flags), 64'd2);
    in_res = 32'h7F800000; set_flags(3'b001);
    tick();
    chk("sticky_011", 64'(sticky_flags), 64'd3);
    chk("sticky_count", 64'(op_count), 64'd2);
    in_res = 32'h00000001; set_flags(3'b100); clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("clrpush_sticky", 64'(sticky_flags), 64'd4);
    chk("clrpush_count", 64'(op_count), 64'd1);
    chk("clrpush_level", 64'(level), 64'd3);
    chk("clrpush_head_flags", 64'(out_flags), 64'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pre_wrap_level", 64'(level), 64'd2);

    // Concurrent push and pop across pointer wrap
    exp_q.push_back(32'h7F800000);
    exp_q.push_back(32'h00000001);
    for (int i = 0; i < 10; i++) begin
      w = 32'hC0DE0000 + 32'(i);
      exp_q.push_back(w);
      in_valid = 1'b1; in_res = w; set_flags(3'b000); out_ready = 1'b1;
      chk("wrap_res", 64'(out_res), 64'(exp_q[0]));
      void'(exp_q.pop_front());
      tick();
      chk("wrap_level", 64'(level), 64'd2);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("wrap_count", 64'(op_count), 64'd11);
    chk("wrap_head", 64'(out_res), 64'(exp_q[0]));

    // Saturation of the 4-bit counter
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_res = 32'h12340000 + 32'(i); set_flags(3'b111); out_ready = 1'b1;
      tick();
      if (i == 14) chk("sat_at_15", 64'(op_count), 64'd15);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("sat_count", 64'(op_count), 64'd15);
    chk("sat_sticky", 64'(sticky_flags), 64'd7);
    chk("sat_level", 64'(level), 64'd2);

    // Asynchronous reset with two entries buffered
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_sticky", 64'(sticky_flags), 64'd0);
    chk("midrst_count", 64'(op_count), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_res", 64'(out_res), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("postrst_valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
